// File: rtl/clkgen_pkg.sv
// Shared constants and helpers for the multi-channel clock/tick divider.
// The divisor encodes a half-period: the output toggles after div+1 input cycles.
package clkgen_pkg;

    localparam int CNT_W_DEF = 32;

    // Half-period divisor for a square wave of f_out from an f_in clock.
    function automatic int unsigned calc_div(input int unsigned f_in, input int unsigned f_out);
        return f_in / (2 * f_out) - 1;
    endfunction

    localparam int DEFAULT_DIV = int'(calc_div(50_000_000, 10_000));

endpackage

// File: rtl/clkgen_chan.sv
// One divider channel: half-period counter, programmable divisor, square wave
// output and a one-cycle tick on every rising edge of that output.
module clkgen_chan
    import clkgen_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = clkgen_pkg::DEFAULT_DIV
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    output logic             clkout,
    output logic             tick,
    output logic [CNT_W-1:0] div
);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            div    <= CNT_W'(DEFAULT_DIV);
            clkout <= 1'b0;
            tick   <= 1'b0;
        end else begin
            // A divisor load lands even when phase-align or disable wins this edge.
            if (ld) begin
                div <= ld_val;
            end

            if (clr || !en) begin
                cnt    <= '0;
                clkout <= 1'b0;
                tick   <= 1'b0;
            end else if (ld) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (cnt >= div) begin
                // >= rather than == so a divisor lowered below the live count still wraps.
                cnt    <= '0;
                clkout <= ~clkout;
                tick   <= ~clkout;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clkgen_multi.sv
// N-channel programmable clock/tick divider with per-channel enable, a global
// phase-align strobe and a read-back bus of every channel's divisor.
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = clkgen_pkg::DEFAULT_DIV
) (
    input  logic                      clkin,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           ch_en,
    input  logic                      sync,
    input  logic                      wr_en,
    input  logic [$clog2(N_CH):0]     wr_ch,
    input  logic [CNT_W-1:0]          wr_div,
    output logic [N_CH-1:0]           clkout,
    output logic [N_CH-1:0]           tick,
    output logic [N_CH*CNT_W-1:0]     div_rd
);

    localparam int WCH_W = $clog2(N_CH) + 1;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             ld;
        logic [CNT_W-1:0] div_q;

        // Out-of-range indices never match any channel, so such writes are dropped.
        assign ld = wr_en && (wr_ch == WCH_W'(i));

        clkgen_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clkin  (clkin),
            .rst_n  (rst_n),
            .en     (ch_en[i]),
            .clr    (sync),
            .ld     (ld),
            .ld_val (wr_div),
            .clkout (clkout[i]),
            .tick   (tick[i]),
            .div    (div_q)
        );

        assign div_rd[i*CNT_W +: CNT_W] = div_q;
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// Self-checking bench for clkgen_multi: directed scenarios plus random traffic,
// all compared against a phase-arithmetic reference model.
module tb_clkgen_multi;

    localparam int N_CH  = 4;
    localparam int CNT_W = 32;
    localparam int WCH_W = $clog2(N_CH) + 1;
    localparam int DEF   = 2499;

    logic                  clkin = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       ch_en;
    logic                  sync;
    logic                  wr_en;
    logic [WCH_W-1:0]      wr_ch;
    logic [CNT_W-1:0]      wr_div;
    logic [N_CH-1:0]       clkout;
    logic [N_CH-1:0]       tick;
    logic [N_CH*CNT_W-1:0] div_rd;

    clkgen_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clkin  (clkin),
        .rst_n  (rst_n),
        .ch_en  (ch_en),
        .sync   (sync),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .clkout (clkout),
        .tick   (tick),
        .div_rd (div_rd)
    );

    always #5 clkin = ~clkin;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: each channel remembers the edge at which its phase last
    // restarted and the level it held then; outputs follow from elapsed edges.
    longint           t = 0;
    longint           t0     [N_CH];
    bit               lvl0   [N_CH];
    logic [CNT_W-1:0] m_div  [N_CH];
    bit               m_clk  [N_CH];
    bit               m_tick [N_CH];

    task automatic model_edge();
        t++;
        for (int c = 0; c < N_CH; c++) begin
            bit     w;
            longint d;
            longint e;
            if (!rst_n) begin
                t0[c] = t; lvl0[c] = 0; m_clk[c] = 0; m_tick[c] = 0; m_div[c] = CNT_W'(DEF);
            end else begin
                w = wr_en && (int'(wr_ch) == c);
                if (w) m_div[c] = wr_div;
                if (sync || !ch_en[c]) begin
                    t0[c] = t; lvl0[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
                end else if (w) begin
                    t0[c] = t; lvl0[c] = m_clk[c]; m_tick[c] = 0;
                end else begin
                    d = longint'(m_div[c]) + 1;
                    e = t - t0[c];
                    m_clk[c]  = lvl0[c] ^ ((e / d) % 2 == 1);
                    m_tick[c] = (e % d == 0) && m_clk[c];
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("clkout%0d@%0d", c, t), clkout[c], m_clk[c]);
            check($sformatf("tick%0d@%0d", c, t), tick[c], m_tick[c]);
            check($sformatf("div%0d@%0d", c, t), div_rd[c*CNT_W +: CNT_W], m_div[c]);
        end
    endtask

    // Inputs are set at the falling edge; one call covers one rising edge.
    task automatic cyc();
        model_edge();
        @(posedge clkin);
        #1;
        compare_all();
        @(negedge clkin);
    endtask

    task automatic write_div(input int ch, input int val);
        wr_en  = 1'b1;
        wr_ch  = WCH_W'(ch);
        wr_div = CNT_W'(val);
        cyc();
        wr_en  = 1'b0;
    endtask

    int               n;
    int               first [3];
    logic             lvl;
    logic [CNT_W-1:0] saved [N_CH];

    initial begin
        rst_n = 1'b0; ch_en = '1; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        for (int c = 0; c < N_CH; c++) begin
            t0[c] = 0; lvl0[c] = 0; m_clk[c] = 0; m_tick[c] = 0; m_div[c] = CNT_W'(DEF);
        end
        @(negedge clkin);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Default divisor: first rise 2500 cycles after reset, then every 5000.
        n = 0;
        do begin cyc(); n++; end while (!tick[0] && n < 6000);
        check("t1_first_rise", n, 2500);
        n = 0;
        do begin cyc(); n++; end while (!tick[0] && n < 6000);
        check("t1_period", n, 5000);

        // div=0 gives clkin/2: four ticks in eight cycles.
        write_div(1, 0);
        n = 0;
        for (int k = 0; k < 8; k++) begin cyc(); n += int'(tick[1]); end
        check("t2_ticks", n, 4);

        // Lowering the divisor mid-count holds the level and restarts the count.
        write_div(2, 9);
        repeat (7) cyc();
        lvl = clkout[2];
        write_div(2, 3);
        check("t3_level_held", clkout[2], lvl);
        n = 0;
        do begin cyc(); n++; end while (clkout[2] == lvl && n < 20);
        check("t3_next_toggle", n, 4);

        // Phase-align: all outputs low, then rises after div+1 cycles each.
        write_div(0, 2);
        write_div(1, 5);
        write_div(2, 9);
        repeat (13) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("t4_sync_low", clkout[2:0], 0);
        first = '{0, 0, 0};
        for (int k = 1; k <= 12; k++) begin
            cyc();
            for (int c = 0; c < 3; c++) if (tick[c] && first[c] == 0) first[c] = k;
        end
        check("t4_rise0", first[0], 3);
        check("t4_rise1", first[1], 6);
        check("t4_rise2", first[2], 10);

        // Disable while high, reprogram while disabled, re-enable.
        write_div(3, 7);
        n = 0;
        do begin cyc(); n++; end while (!clkout[3] && n < 40);
        check("t5_high", clkout[3], 1);
        cyc();
        ch_en[3] = 1'b0;
        cyc();
        check("t5_dis_low", clkout[3], 0);
        check("t5_dis_tick", tick[3], 0);
        write_div(3, 4);
        check("t5_div_while_dis", div_rd[3*CNT_W +: CNT_W], 4);
        ch_en[3] = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!tick[3] && n < 20);
        check("t5_reen_rise", n, 5);

        // Out-of-range write indices leave every divisor alone.
        for (int c = 0; c < N_CH; c++) saved[c] = div_rd[c*CNT_W +: CNT_W];
        write_div(N_CH, 123);
        write_div(7, 55);
        for (int c = 0; c < N_CH; c++)
            check($sformatf("t6_oob_div%0d", c), div_rd[c*CNT_W +: CNT_W], saved[c]);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0) ch_en = N_CH'($urandom);
            sync   = ($urandom_range(31) == 0);
            wr_en  = ($urandom_range(3) == 0);
            wr_ch  = WCH_W'($urandom_range(7));
            wr_div = CNT_W'($urandom_range(11));
            cyc();
        end
        sync = 1'b0; wr_en = 1'b0; ch_en = '1;
        write_div(1, 0);
        repeat (3) cyc();

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_clkout", clkout, 0);
        check("t6_rst_tick", tick, 0);
        for (int c = 0; c < N_CH; c++)
            check($sformatf("t6_rst_div%0d", c), div_rd[c*CNT_W +: CNT_W], DEF);
        cyc();
        rst_n = 1'b1;
        repeat (20) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
